// File: rtl/prefix_chunk_adder_seq.sv
// Multi-cycle wide adder built around one CHUNK-bit parallel-prefix carry network.
// The operands are walked least-significant chunk first, one chunk per clock.
// The carry between chunks lives in a register that feeds the prefix carry-in.

// Prefix carry network: gout[i] = carry out of bit i given gen/prp and cin.
// SPEED selects the topology: 0 ripple, 1 Brent-Kung, 2 Sklansky.
module prefix_and_or_cfast #(
    parameter int WIDTH = 8,
    parameter int SPEED = 1
) (
    input  logic [WIDTH-1:0] gen,
    input  logic [WIDTH-1:0] prp,
    input  logic             cin,
    output logic [WIDTH-1:0] gout
);
    localparam int NL = $clog2(WIDTH);

    logic [WIDTH-1:0] g_w;
    logic [WIDTH-1:0] p_w;
    logic [WIDTH-1:0] g_n;
    logic [WIDTH-1:0] p_n;
    logic             carry_w;

    // Build the group generate for each prefix [i:0], with cin folded into bit 0
    always_comb begin
        g_w     = gen;
        p_w     = prp;
        g_n     = '0;
        p_n     = '0;
        carry_w = cin;
        g_w[0]  = gen[0] | (prp[0] & cin);
        if (SPEED == 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                g_w[i]  = gen[i] | (prp[i] & carry_w);
                carry_w = g_w[i];
            end
        end else if (SPEED == 2) begin
            // Sklansky: each level doubles the span, upper half of a block takes the block's lower prefix
            for (int l = 0; l < NL; l++) begin
                g_n = g_w;
                p_n = p_w;
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i >> l) & 1) == 1) begin
                        g_n[i] = g_w[i] | (p_w[i] & g_w[((i >> l) << l) - 1]);
                        p_n[i] = p_w[i] & p_w[((i >> l) << l) - 1];
                    end
                end
                g_w = g_n;
                p_w = p_n;
            end
        end else begin
            // Brent-Kung up-sweep: combine pairs at doubling strides
            for (int l = 0; l < NL; l++) begin
                g_n = g_w;
                p_n = p_w;
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i + 1) % (2 << l)) == 0) begin
                        g_n[i] = g_w[i] | (p_w[i] & g_w[i - (1 << l)]);
                        p_n[i] = p_w[i] & p_w[i - (1 << l)];
                    end
                end
                g_w = g_n;
                p_w = p_n;
            end
            // Brent-Kung down-sweep: fill in the intermediate positions
            for (int l = NL - 2; l >= 0; l--) begin
                g_n = g_w;
                p_n = p_w;
                for (int i = 0; i < WIDTH; i++) begin
                    if ((((i + 1) % (2 << l)) == (1 << l)) && (i >= (2 << l))) begin
                        g_n[i] = g_w[i] | (p_w[i] & g_w[i - (1 << l)]);
                        p_n[i] = p_w[i] & p_w[i - (1 << l)];
                    end
                end
                g_w = g_n;
                p_w = p_n;
            end
        end
        gout = g_w;
    end
endmodule

module prefix_chunk_adder_seq #(
    parameter int OPW   = 32,
    parameter int CHUNK = 8,
    parameter int SPEED = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic           ci,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] s,
    output logic           co,
    output logic           prop
);
    localparam int NCH = (OPW + CHUNK - 1) / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = NCH * CHUNK;
    localparam int R   = OPW % CHUNK;
    // Carry out of the top real bit; padding bits above it must not influence CO
    localparam int COI = (R != 0) ? (R - 1) : (CHUNK - 1);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic [PW-1:0]    a_reg, b_reg;
    logic             carry_reg;
    logic             prop_acc_reg;
    logic [OPW-1:0]   s_reg;
    logic             co_reg;
    logic             prop_reg;

    logic             accept;
    logic             last_chunk;
    int               base;
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic [CHUNK-1:0] gen, prp, go, sum, valid_mask;
    logic             chunk_prop;

    // Select the current chunk and form its local generate/propagate and sum
    always_comb begin
        base       = int'(cnt_reg) * CHUNK;
        a_chunk    = a_reg[base +: CHUNK];
        b_chunk    = b_reg[base +: CHUNK];
        gen        = a_chunk & b_chunk;
        prp        = a_chunk ^ b_chunk;
        valid_mask = '0;
        for (int i = 0; i < CHUNK; i++) begin
            valid_mask[i] = ((base + i) < OPW);
        end
        chunk_prop = &(prp | ~valid_mask);
        sum        = prp ^ {go[CHUNK-2:0], carry_reg};
        last_chunk = (cnt_reg == LAST);
    end

    prefix_and_or_cfast #(
        .WIDTH (CHUNK),
        .SPEED (SPEED)
    ) u_prefix (
        .gen  (gen),
        .prp  (prp),
        .cin  (carry_reg),
        .gout (go)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, per-chunk sum write-back and carry/propagate chaining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg      <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            carry_reg    <= 1'b0;
            prop_acc_reg <= 1'b0;
            s_reg        <= '0;
            co_reg       <= 1'b0;
            prop_reg     <= 1'b0;
        end else if (accept) begin
            a_reg        <= PW'(a);
            b_reg        <= PW'(b);
            carry_reg    <= ci;
            prop_acc_reg <= 1'b1;
            cnt_reg      <= '0;
        end else if (state_reg == RUN) begin
            for (int i = 0; i < CHUNK; i++) begin
                if ((base + i) < OPW) begin
                    s_reg[base + i] <= sum[i];
                end
            end
            carry_reg    <= go[CHUNK-1];
            prop_acc_reg <= prop_acc_reg & chunk_prop;
            if (last_chunk) begin
                co_reg   <= go[COI];
                prop_reg <= prop_acc_reg & chunk_prop;
            end else begin
                cnt_reg  <= cnt_reg + CW'(1);
            end
        end
    end

    assign s    = s_reg;
    assign co   = co_reg;
    assign prop = prop_reg;
endmodule

// File: tb/tb_prefix_chunk_adder_seq.sv
// Directed and lightly randomised checks of the chunked adder on three configurations:
// 32-bit Brent-Kung, 20-bit Sklansky (partial last chunk) and 64-bit ripple.
module tb_prefix_chunk_adder_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  in_valid, out_ready, in_ready, out_valid, co, prop;
    logic [63:0] a_in, b_in;
    logic        ci_in;
    logic [31:0] s0;
    logic [19:0] s1;
    logic [63:0] s2;
    logic [63:0] s_mux [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign s_mux[0] = {32'b0, s0};
    assign s_mux[1] = {44'b0, s1};
    assign s_mux[2] = s2;

    prefix_chunk_adder_seq #(.OPW(32), .CHUNK(8), .SPEED(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_in[31:0]), .b(b_in[31:0]), .ci(ci_in), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .s(s0), .co(co[0]), .prop(prop[0]));

    prefix_chunk_adder_seq #(.OPW(20), .CHUNK(8), .SPEED(2)) dut20 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_in[19:0]), .b(b_in[19:0]), .ci(ci_in), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .s(s1), .co(co[1]), .prop(prop[1]));

    prefix_chunk_adder_seq #(.OPW(64), .CHUNK(8), .SPEED(0)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_in), .b(b_in), .ci(ci_in), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .s(s2), .co(co[2]), .prop(prop[2]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int nch_of(input int sel);
        return (sel == 0) ? 4 : ((sel == 1) ? 3 : 8);
    endfunction

    function automatic int width_of(input int sel);
        return (sel == 0) ? 32 : ((sel == 1) ? 20 : 64);
    endfunction

    // Reference: {prop, co, sum} for an w-bit add
    function automatic logic [65:0] model(input int w, input logic [63:0] av,
                                          input logic [63:0] bv, input logic civ);
        logic [63:0] mask;
        logic [64:0] full;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        full = {1'b0, av & mask} + {1'b0, bv & mask} + 65'(civ);
        return {(((av ^ bv) & mask) == mask), full[w], full[63:0] & mask};
    endfunction

    // One operation on DUT sel: accept, latency, optional DONE stall, result, handshake
    task automatic run_op(input int sel, input logic [63:0] av, input logic [63:0] bv,
                          input logic civ, input int stall, input logic [63:0] es,
                          input logic eco, input logic eprop, input string tag);
        int          lat;
        bit          got;
        logic [63:0] held_s;
        logic        held_co;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            if (in_ready[sel]) got = 1;
            else begin @(posedge clk); #1; end
        end
        check({tag, " idle"}, 64'(got), 64'd1);
        if (!got) return;
        @(negedge clk);
        a_in = av; b_in = bv; ci_in = civ; in_valid[sel] = 1'b1;
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
        a_in = ~av; b_in = {$urandom, $urandom}; ci_in = ~civ;
        got = 0; lat = 0;
        for (int i = 1; i <= 40 && !got; i++) begin
            @(posedge clk); #1;
            if (out_valid[sel]) begin got = 1; lat = i; end
        end
        check({tag, " done"}, 64'(got), 64'd1);
        if (!got) return;
        check({tag, " latency"}, 64'(lat), 64'(nch_of(sel)));
        if (stall > 0) begin
            held_s  = s_mux[sel];
            held_co = co[sel];
            in_valid[sel] = 1'b1;
            a_in = {$urandom, $urandom};
            repeat (stall) @(posedge clk);
            #1;
            in_valid[sel] = 1'b0;
            check({tag, " stall s"}, s_mux[sel], held_s);
            check({tag, " stall co"}, 64'(co[sel]), 64'(held_co));
            check({tag, " stall in_ready"}, 64'(in_ready[sel]), 64'd0);
            check({tag, " stall out_valid"}, 64'(out_valid[sel]), 64'd1);
        end
        check({tag, " s"}, s_mux[sel], es);
        check({tag, " co"}, 64'(co[sel]), 64'(eco));
        check({tag, " prop"}, 64'(prop[sel]), 64'(eprop));
        $display("op %s dut%0d w=%0d a=%h b=%h ci=%0d -> s=%h co=%0d prop=%0d lat=%0d stall=%0d",
                 tag, sel, width_of(sel), av, bv, civ, s_mux[sel], co[sel], prop[sel], lat, stall);
        out_ready[sel] = 1'b1;
        @(posedge clk); #1;
        out_ready[sel] = 1'b0;
        check({tag, " post out_valid"}, 64'(out_valid[sel]), 64'd0);
        check({tag, " post in_ready"}, 64'(in_ready[sel]), 64'd1);
    endtask

    initial begin
        logic [63:0] av, bv;
        logic        civ;
        logic [65:0] exp_v;

        rst_n = 1'b0; in_valid = '0; out_ready = '0;
        a_in = '0; b_in = '0; ci_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int sel = 0; sel < 3; sel++) begin
            check("reset in_ready", 64'(in_ready[sel]), 64'd1);
            check("reset out_valid", 64'(out_valid[sel]), 64'd0);
            check("reset s", s_mux[sel], 64'd0);
            check("reset co", 64'(co[sel]), 64'd0);
            check("reset prop", 64'(prop[sel]), 64'd0);
        end
        @(negedge clk); rst_n = 1'b1;

        run_op(0, 64'hFFFFFFFF, 64'h00000001, 1'b0, 0, 64'h00000000, 1'b1, 1'b0, "ovf32");
        run_op(0, 64'h12345678, 64'h11111111, 1'b1, 0, 64'h2345678A, 1'b0, 1'b0, "mix32");
        run_op(0, 64'hAAAAAAAA, 64'h55555555, 1'b1, 0, 64'h00000000, 1'b1, 1'b1, "prop32");

        // Asynchronous reset while chunk 2 is being processed
        @(negedge clk);
        a_in = 64'h12345678; b_in = 64'h11111111; ci_in = 1'b1; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid[0]), 64'd0);
        check("midrst in_ready", 64'(in_ready[0]), 64'd1);
        check("midrst s", s_mux[0], 64'd0);
        check("midrst co", 64'(co[0]), 64'd0);
        check("midrst prop", 64'(prop[0]), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        run_op(0, 64'h1, 64'h2, 1'b0, 0, 64'h3, 1'b0, 1'b0, "after_rst");

        run_op(0, 64'hDEADBEEF, 64'h01234567, 1'b1, 10, 64'hDFD10457, 1'b0, 1'b0, "stall32");

        run_op(1, 64'hFFFFF, 64'h00001, 1'b0, 0, 64'h00000, 1'b1, 1'b0, "ovf20");
        run_op(1, 64'h80000, 64'h80000, 1'b0, 0, 64'h00000, 1'b1, 1'b0, "top20");
        run_op(1, 64'hFFFFF, 64'h00000, 1'b1, 2, 64'h00000, 1'b1, 1'b1, "prop20");

        run_op(2, 64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b0, 0, 64'h0, 1'b1, 1'b0, "ovf64");
        run_op(2, 64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0, 0,
               64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, "prop64");

        for (int n = 0; n < 20; n++) begin
            for (int sel = 0; sel < 3; sel++) begin
                av  = {$urandom, $urandom};
                bv  = (n % 5 == 0) ? ~av : {$urandom, $urandom};
                civ = 1'($urandom_range(0, 1));
                exp_v = model(width_of(sel), av, bv, civ);
                run_op(sel, av, bv, civ, int'($urandom_range(0, 3)),
                       exp_v[63:0], exp_v[64], exp_v[65], "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
